switch_debouncer: RTL and testbench



---
 rtl/switch_debouncer.sv | 145 ++++++++++++++
 tb/tb_switch_debouncer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// Per-channel 2-flop synchronizer plus counter-based stability filter for raw board switches.
// Optional sticky change flags (sw_changed / chg_clr) are built when SW_CHANGE_LATCH_EN is defined.
module switch_debouncer #(
    parameter int unsigned N_SW            = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N_SW-1:0] raw_sw,
    output logic [N_SW-1:0] sw_out,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall
`ifdef SW_CHANGE_LATCH_EN
    ,
    output logic [N_SW-1:0] sw_changed,
    input  logic [N_SW-1:0] chg_clr
`endif
);

    typedef enum logic [1:0] {
        StStable0,
        StPend1,
        StStable1,
        StPend0
    } state_e;

    localparam logic [CNT_W-1:0] DebCnt = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [N_SW-1:0]  s1_q, s2_q;
    logic [N_SW-1:0]  out_q, out_d;
    logic [N_SW-1:0]  rise_q, rise_d;
    logic [N_SW-1:0]  fall_q, fall_d;
    state_e           state_q [N_SW];
    state_e           state_d [N_SW];
    logic [CNT_W-1:0] cnt_q   [N_SW];
    logic [CNT_W-1:0] cnt_d   [N_SW];

    always_comb begin
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < N_SW; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                StStable0: begin
                    if (s2_q[i]) begin
                        state_d[i] = StPend1;
                        cnt_d[i]   = CntOne;
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
                StPend1: begin
                    if (!s2_q[i]) begin
                        state_d[i] = StStable0;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == DebCnt) begin
                        state_d[i] = StStable1;
                        out_d[i]   = 1'b1;
                        rise_d[i]  = 1'b1;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntOne;
                    end
                end
                StStable1: begin
                    if (!s2_q[i]) begin
                        state_d[i] = StPend0;
                        cnt_d[i]   = CntOne;
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
                StPend0: begin
                    if (s2_q[i]) begin
                        state_d[i] = StStable1;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == DebCnt) begin
                        state_d[i] = StStable0;
                        out_d[i]   = 1'b0;
                        fall_d[i]  = 1'b1;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntOne;
                    end
                end
                default: begin
                    state_d[i] = StStable0;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_q   <= '0;
            s2_q   <= '0;
            out_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < N_SW; i++) begin
                state_q[i] <= StStable0;
                cnt_q[i]   <= '0;
            end
        end else begin
            s1_q   <= raw_sw;
            s2_q   <= s1_q;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int i = 0; i < N_SW; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign sw_out  = out_q;
    assign sw_rise = rise_q;
    assign sw_fall = fall_q;

`ifdef SW_CHANGE_LATCH_EN
    logic [N_SW-1:0] chg_q, chg_d;

    // Set from the next-state pulses so the flag rises with the pulse; set beats clear.
    always_comb begin
        chg_d = (chg_q & ~chg_clr) | rise_d | fall_d;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            chg_q <= '0;
        end else begin
            chg_q <= chg_d;
        end
    end

    assign sw_changed = chg_q;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed scenarios plus random switch activity,
// checked every cycle against a run-length reference model.
module tb_switch_debouncer;

    localparam int D = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] raw_sw = 2'b00;
    logic [1:0] chg_clr = 2'b00;
    logic [1:0] sw_out, sw_rise, sw_fall;
`ifdef SW_CHANGE_LATCH_EN
    logic [1:0] sw_changed;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [1:0] m_s1, m_s2, m_out, m_rise, m_fall, m_chg;
    int         m_run [2];

    switch_debouncer #(
        .N_SW           (2),
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (8)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .raw_sw (raw_sw),
        .sw_out (sw_out),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall)
`ifdef SW_CHANGE_LATCH_EN
        ,
        .sw_changed(sw_changed),
        .chg_clr   (chg_clr)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got %b expected %b", tag, got, exp);
        end
    endtask

    // A new level is accepted once D+1 consecutive synchronized samples differ from it.
    task automatic model_edge();
        if (!reset) begin
            m_s1 = '0; m_s2 = '0; m_out = '0; m_rise = '0; m_fall = '0; m_chg = '0;
            m_run[0] = 0; m_run[1] = 0;
        end else begin
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < 2; i++) begin
                if (m_s2[i] != m_out[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D + 1) begin
                        m_out[i] = m_s2[i];
                        if (m_s2[i]) m_rise[i] = 1'b1;
                        else         m_fall[i] = 1'b1;
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                if (m_rise[i] || m_fall[i]) m_chg[i] = 1'b1;
                else if (chg_clr[i])        m_chg[i] = 1'b0;
            end
            m_s2 = m_s1;
            m_s1 = raw_sw;
        end
    endtask

    task automatic tick(input logic [1:0] r, input logic rst, input logic [1:0] clr);
        @(negedge clock);
        raw_sw  = r;
        reset   = rst;
        chg_clr = clr;
        @(posedge clock);
        model_edge();
        #1;
        check("sw_out", sw_out, m_out);
        check("sw_rise", sw_rise, m_rise);
        check("sw_fall", sw_fall, m_fall);
        check("pulse_excl", sw_rise & sw_fall, 2'b00);
`ifdef SW_CHANGE_LATCH_EN
        check("sw_changed", sw_changed, m_chg);
`endif
    endtask

    task automatic hold(input logic [1:0] r, input int n);
        for (int j = 0; j < n; j++) tick(r, 1'b1, 2'b00);
    endtask

    initial begin
        logic [1:0] bounce [6];
        logic [1:0] r;
        int         len;

        // Reset held with switches high: everything stays zero
        for (int j = 0; j < 3; j++) begin
            tick(2'b11, 1'b0, 2'b00);
            check("rst_out", sw_out, 2'b00);
            check("rst_rise", sw_rise, 2'b00);
            check("rst_fall", sw_fall, 2'b00);
        end
        // Release: the release edge is j=0, acceptance D+2 edges later
        for (int j = 0; j < 8; j++) begin
            tick(2'b11, 1'b1, 2'b00);
            check("rel_out", sw_out, (j >= D + 2) ? 2'b11 : 2'b00);
            check("rel_rise", sw_rise, (j == D + 2) ? 2'b11 : 2'b00);
        end
        hold(2'b00, 8);

        // Clean rise on channel 0 only
        for (int j = 0; j < 8; j++) begin
            tick(2'b01, 1'b1, 2'b00);
            check("rise_out", sw_out, (j >= D + 2) ? 2'b01 : 2'b00);
            check("rise_pulse", sw_rise, (j == D + 2) ? 2'b01 : 2'b00);
        end
`ifdef SW_CHANGE_LATCH_EN
        check("chg_set", sw_changed, 2'b01);
        tick(2'b01, 1'b1, 2'b01);
        check("chg_clr", sw_changed, 2'b00);
`endif

        // Channel 1 high, then a 3-cycle low glitch must be rejected
        hold(2'b11, 8);
        for (int j = 0; j < 3; j++) begin
            tick(2'b01, 1'b1, 2'b00);
            check("glitch_out", sw_out, 2'b11);
        end
        for (int j = 0; j < 8; j++) begin
            tick(2'b11, 1'b1, 2'b00);
            check("glitch_out", sw_out, 2'b11);
            check("glitch_fall", sw_fall, 2'b00);
        end
        // Real fall on channel 1; clear coincides with the fall edge, set wins
        for (int j = 0; j < 8; j++) begin
            tick(2'b01, 1'b1, (j == D + 2) ? 2'b10 : 2'b00);
            check("fall_out", sw_out, (j >= D + 2) ? 2'b01 : 2'b11);
            check("fall_pulse", sw_fall, (j == D + 2) ? 2'b10 : 2'b00);
        end
`ifdef SW_CHANGE_LATCH_EN
        check("chg_set_wins", sw_changed & 2'b10, 2'b10);
`endif

        // Bounce on channel 0 is rejected, then a held level is accepted once
        hold(2'b00, 8);
        bounce[0] = 2'b01; bounce[1] = 2'b00; bounce[2] = 2'b01;
        bounce[3] = 2'b01; bounce[4] = 2'b00; bounce[5] = 2'b01;
        for (int j = 0; j < 6; j++) begin
            tick(bounce[j], 1'b1, 2'b00);
            check("bounce_out", sw_out, 2'b00);
        end
        for (int j = 0; j < 8; j++) begin
            tick(2'b00, 1'b1, 2'b00);
            check("bounce_out", sw_out, 2'b00);
            check("bounce_rise", sw_rise, 2'b00);
        end
        for (int j = 0; j < 8; j++) begin
            tick(2'b01, 1'b1, 2'b00);
            check("held_rise", sw_rise, (j == D + 2) ? 2'b01 : 2'b00);
        end

        // Reset while pending discards the partial count
        hold(2'b00, 8);
        for (int j = 0; j < 5; j++) begin
            tick(2'b01, (j == 4) ? 1'b0 : 1'b1, 2'b00);
            check("midrst_rise", sw_rise, 2'b00);
        end
        for (int j = 0; j < 8; j++) begin
            tick(2'b01, 1'b1, 2'b00);
            check("midrst_out", sw_out, (j >= D + 2) ? 2'b01 : 2'b00);
            check("midrst_rise", sw_rise, (j == D + 2) ? 2'b01 : 2'b00);
        end

        // Random activity: short glitches mixed with long holds, occasional reset/clear
        for (int s = 0; s < 300; s++) begin
            r   = 2'($urandom_range(0, 3));
            len = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 4))
                                              : int'($urandom_range(5, 10));
            for (int j = 0; j < len; j++) begin
                tick(r, ($urandom_range(0, 60) != 0),
                     ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
